// File: rtl/kernel_sysid_checker.sv
// Avalon-MM master that reads the sysid slave's ID and timestamp words and checks them against expected constants.
// Trigger to done takes 3 + 2*READ_LATENCY cycles plus stalls; waitrequest stalls the read until TIMEOUT_CYCLES, then aborts.
module kernel_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1483507502,
  parameter int          READ_LATENCY       = 0,
  parameter int          RECHECK_CYCLES     = 50000000,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [7:0]  fail_count
);

  localparam int               TMR_W     = (RECHECK_CYCLES > 1) ? $clog2(RECHECK_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'((RECHECK_CYCLES > 0) ? RECHECK_CYCLES - 1 : 0);
  localparam logic [15:0]      WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       LAT_LAST  = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

  typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, EVAL} state_t;

  state_t             state_q, state_d;
  logic               m_read_q, m_read_d;
  logic               m_address_q, m_address_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               id_match_q, id_match_d;
  logic               ts_match_q, ts_match_d;
  logic               pass_q, pass_d;
  logic               timeout_err_q, timeout_err_d;
  logic [31:0]        id_value_q, id_value_d;
  logic [31:0]        ts_value_q, ts_value_d;
  logic [7:0]         fail_count_q, fail_count_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [15:0]        wait_cnt_q, wait_cnt_d;
  logic [1:0]         lat_cnt_q, lat_cnt_d;

  logic timer_hit, trigger, cap_id, cap_ts;

  always_comb begin
    state_d       = state_q;
    m_read_d      = m_read_q;
    m_address_d   = m_address_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    id_match_d    = id_match_q;
    ts_match_d    = ts_match_q;
    pass_d        = pass_q;
    timeout_err_d = timeout_err_q;
    id_value_d    = id_value_q;
    ts_value_d    = ts_value_q;
    fail_count_d  = fail_count_q;
    timer_d       = timer_q;
    wait_cnt_d    = wait_cnt_q;
    lat_cnt_d     = lat_cnt_q;
    cap_id        = 1'b0;
    cap_ts        = 1'b0;

    timer_hit = (RECHECK_CYCLES != 0) && (timer_q == TMR_LAST);
    trigger   = start || timer_hit;
    if ((RECHECK_CYCLES != 0) && (state_q == IDLE)) timer_d = timer_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d     = RD_ID;
          m_read_d    = 1'b1;
          m_address_d = 1'b0;
          busy_d      = 1'b1;
          wait_cnt_d  = '0;
        end
      end
      RD_ID, RD_TS: begin
        // m_read is always high here, so an accept is just a low waitrequest
        if (!m_waitrequest) begin
          wait_cnt_d = '0;
          if (READ_LATENCY == 0) begin
            cap_id = (state_q == RD_ID);
            cap_ts = (state_q == RD_TS);
          end else begin
            m_read_d  = 1'b0;
            lat_cnt_d = '0;
            state_d   = (state_q == RD_ID) ? LAT_ID : LAT_TS;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d       = IDLE;
          m_read_d      = 1'b0;
          busy_d        = 1'b0;
          timeout_err_d = 1'b1;
          pass_d        = 1'b0;
          done_d        = 1'b1;
          wait_cnt_d    = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      LAT_ID, LAT_TS: begin
        if (lat_cnt_q == LAT_LAST) begin
          cap_id = (state_q == LAT_ID);
          cap_ts = (state_q == LAT_TS);
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      EVAL: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        m_address_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (cap_id) begin
      id_value_d  = m_readdata;
      state_d     = RD_TS;
      m_read_d    = 1'b1;
      m_address_d = 1'b1;
    end

    // Results are registered on entry to EVAL so they line up with the done pulse
    if (cap_ts) begin
      ts_value_d    = m_readdata;
      state_d       = EVAL;
      m_read_d      = 1'b0;
      id_match_d    = (id_value_q == EXPECTED_ID);
      ts_match_d    = (m_readdata == EXPECTED_TIMESTAMP);
      pass_d        = (id_value_q == EXPECTED_ID) && (m_readdata == EXPECTED_TIMESTAMP);
      timeout_err_d = 1'b0;
      done_d        = 1'b1;
    end

    if (done_d) begin
      timer_d = '0;
      if (!pass_d && (fail_count_q != 8'hFF)) fail_count_d = fail_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      m_read_q      <= 1'b0;
      m_address_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      id_match_q    <= 1'b0;
      ts_match_q    <= 1'b0;
      pass_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      id_value_q    <= '0;
      ts_value_q    <= '0;
      fail_count_q  <= '0;
      timer_q       <= '0;
      wait_cnt_q    <= '0;
      lat_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      m_read_q      <= m_read_d;
      m_address_q   <= m_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      id_match_q    <= id_match_d;
      ts_match_q    <= ts_match_d;
      pass_q        <= pass_d;
      timeout_err_q <= timeout_err_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
      fail_count_q  <= fail_count_d;
      timer_q       <= timer_d;
      wait_cnt_q    <= wait_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
    end
  end

  assign m_read      = m_read_q;
  assign m_address   = m_address_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_match    = id_match_q;
  assign ts_match    = ts_match_q;
  assign pass        = pass_q;
  assign timeout_err = timeout_err_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
  assign fail_count  = fail_count_q;

endmodule

// File: tb/tb_kernel_sysid_checker.sv
// Bench for kernel_sysid_checker: three instances (zero latency, latency 2, periodic recheck) each with its own slave model.
module tb_kernel_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1483507502;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // zero-latency instance, stalls only on the timestamp read
  logic        rst_n0, start0, m_address0, m_read0, waitreq0, busy0, done0;
  logic        id_match0, ts_match0, pass0, timeout_err0;
  logic [31:0] readdata0, id_value0, ts_value0, id_resp0, ts_resp0;
  logic [7:0]  fail_count0;
  int          stall_lim0;
  int          stall_seen0 = 0;
  logic        acc_log0[$];

  assign readdata0 = m_address0 ? ts_resp0 : id_resp0;
  assign waitreq0  = m_read0 && m_address0 && (stall_seen0 < stall_lim0);
  always @(posedge clk) begin
    if (m_read0 && m_address0 && waitreq0) stall_seen0 <= stall_seen0 + 1;
    else if (!(m_read0 && m_address0)) stall_seen0 <= 0;
    if (m_read0 && !waitreq0) acc_log0.push_back(m_address0);
  end

  kernel_sysid_checker #(.READ_LATENCY(0), .RECHECK_CYCLES(0)) dut0 (
    .clock(clk), .reset_n(rst_n0), .start(start0), .m_address(m_address0), .m_read(m_read0),
    .m_waitrequest(waitreq0), .m_readdata(readdata0), .busy(busy0), .done(done0),
    .id_match(id_match0), .ts_match(ts_match0), .pass(pass0), .timeout_err(timeout_err0),
    .id_value(id_value0), .ts_value(ts_value0), .fail_count(fail_count0));

  // latency-2 instance: data valid exactly two cycles after accept, garbage otherwise
  logic        rst_n2, start2, m_address2, m_read2, waitreq2, busy2, done2;
  logic        id_match2, ts_match2, pass2, timeout_err2;
  logic [31:0] readdata2, id_value2, ts_value2, id2, ts2;
  logic [7:0]  fail_count2;
  logic        pv0, pa0, pv1, pa1;

  assign waitreq2 = 1'b0;
  always @(posedge clk) begin
    pv0 <= m_read2 && !waitreq2;
    pa0 <= m_address2;
    pv1 <= pv0;
    pa1 <= pa0;
  end
  always @(negedge clk) readdata2 = pv1 ? (pa1 ? ts2 : id2) : $urandom;

  kernel_sysid_checker #(.READ_LATENCY(2), .RECHECK_CYCLES(0)) dut2 (
    .clock(clk), .reset_n(rst_n2), .start(start2), .m_address(m_address2), .m_read(m_read2),
    .m_waitrequest(waitreq2), .m_readdata(readdata2), .busy(busy2), .done(done2),
    .id_match(id_match2), .ts_match(ts_match2), .pass(pass2), .timeout_err(timeout_err2),
    .id_value(id_value2), .ts_value(ts_value2), .fail_count(fail_count2));

  // periodic instance with a slave that always returns a wrong ID
  logic        rst_nr, startr, m_addressr, m_readr, waitreqr, busyr, doner;
  logic        id_matchr, ts_matchr, passr, timeout_errr;
  logic [31:0] readdatar, id_valuer, ts_valuer;
  logic [7:0]  fail_countr;

  assign waitreqr  = 1'b0;
  assign readdatar = m_addressr ? EXP_TS : 32'hDEAD_BEEF;

  kernel_sysid_checker #(.READ_LATENCY(0), .RECHECK_CYCLES(100)) dutr (
    .clock(clk), .reset_n(rst_nr), .start(startr), .m_address(m_addressr), .m_read(m_readr),
    .m_waitrequest(waitreqr), .m_readdata(readdatar), .busy(busyr), .done(doner),
    .id_match(id_matchr), .ts_match(ts_matchr), .pass(passr), .timeout_err(timeout_errr),
    .id_value(id_valuer), .ts_value(ts_valuer), .fail_count(fail_countr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run0(output int cyc);
    acc_log0.delete();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    cyc = 1;
    while (done0 !== 1'b1 && cyc < 2000) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int          cyc, since, ndone, dcyc, fc0, fc2, fcr;
    logic        exp_pass, got;
    logic [31:0] d_id, d_ts, d_pass;

    rst_n0 = 0; rst_n2 = 0; rst_nr = 0;
    start0 = 0; start2 = 0; startr = 0;
    stall_lim0 = 0; id_resp0 = EXP_ID; ts_resp0 = EXP_TS; id2 = 0; ts2 = 0;
    fc0 = 0; fc2 = 0; fcr = 0;
    repeat (3) tick();

    check("rst0_flags", {m_read0, m_address0, busy0, done0, id_match0, ts_match0, pass0, timeout_err0}, 0);
    check("rst0_vals", id_value0 | ts_value0 | {24'd0, fail_count0}, 0);
    check("rst2_flags", {m_read2, m_address2, busy2, done2, id_match2, ts_match2, pass2, timeout_err2}, 0);
    check("rstr_flags", {m_readr, m_addressr, busyr, doner, passr, timeout_errr, fail_countr}, 0);

    rst_n0 = 1; rst_n2 = 1;
    tick();

    // clean check
    run0(cyc);
    check("clean_cycles", cyc, 3);
    check("clean_naccept", acc_log0.size(), 2);
    check("clean_addr0", {31'd0, acc_log0[0]}, 0);
    check("clean_addr1", {31'd0, acc_log0[1]}, 1);
    check("clean_id", id_value0, EXP_ID);
    check("clean_ts", ts_value0, EXP_TS);
    check("clean_flags", {id_match0, ts_match0, pass0, timeout_err0, busy0}, 5'b11101);
    check("clean_fails", fail_count0, 0);
    tick();
    check("clean_after", {busy0, done0, m_read0}, 0);

    // off-by-one timestamp
    ts_resp0 = EXP_TS + 1;
    run0(cyc);
    fc0++;
    check("badts_cycles", cyc, 3);
    check("badts_flags", {id_match0, ts_match0, pass0}, 3'b100);
    check("badts_fails", fail_count0, fc0);
    tick();

    // random data and short stalls on the timestamp read
    for (int i = 0; i < 8; i++) begin
      id_resp0   = ($urandom_range(0, 1) == 1) ? EXP_ID : ($urandom | 32'h1);
      ts_resp0   = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
      stall_lim0 = $urandom_range(0, 5);
      exp_pass   = (id_resp0 == EXP_ID) && (ts_resp0 == EXP_TS);
      run0(cyc);
      if (!exp_pass && fc0 < 255) fc0++;
      check("rnd_cycles", cyc, 3 + stall_lim0);
      check("rnd_id", id_value0, id_resp0);
      check("rnd_ts", ts_value0, ts_resp0);
      check("rnd_match", {id_match0, ts_match0, pass0}, {id_resp0 == EXP_ID, ts_resp0 == EXP_TS, exp_pass});
      check("rnd_fails", fail_count0, fc0);
      tick();
    end

    // one stall short of the timeout still completes
    id_resp0 = EXP_ID; ts_resp0 = EXP_TS; stall_lim0 = 254;
    run0(cyc);
    check("stall254_cycles", cyc, 257);
    check("stall254_flags", {timeout_err0, pass0}, 2'b01);
    tick();

    // timeout on the timestamp read
    stall_lim0 = 1000000;
    run0(cyc);
    fc0++;
    check("tmo_cycles", cyc, 257);
    check("tmo_flags", {timeout_err0, pass0, m_read0, busy0}, 4'b1000);
    check("tmo_kept", {id_match0, ts_match0}, 2'b11);
    check("tmo_kept_ts", ts_value0, EXP_TS);
    check("tmo_fails", fail_count0, fc0);
    tick();
    check("tmo_pulse", done0, 0);

    stall_lim0 = 0;
    run0(cyc);
    check("recover_cycles", cyc, 3);
    check("recover_flags", {timeout_err0, pass0}, 2'b01);
    check("recover_fails", fail_count0, fc0);
    tick();

    // latency 2, garbage off-cycle, extra start while busy
    for (int i = 0; i < 4; i++) begin
      id2 = ($urandom_range(0, 1) == 1) ? EXP_ID : ($urandom | 32'h1);
      ts2 = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
      exp_pass = (id2 == EXP_ID) && (ts2 == EXP_TS);
      if (!exp_pass) fc2++;
      ndone = 0; dcyc = 0; d_id = 0; d_ts = 0; d_pass = 0;
      start2 = 1;
      for (int c = 1; c <= 30; c++) begin
        tick();
        start2 = (c == 3);
        if (done2 === 1'b1) begin
          ndone++;
          if (dcyc == 0) begin
            dcyc = c; d_id = id_value2; d_ts = ts_value2; d_pass = {31'd0, pass2};
          end
        end
      end
      start2 = 0;
      check("lat2_ndone", ndone, 1);
      check("lat2_cycle", dcyc, 7);
      check("lat2_id", d_id, id2);
      check("lat2_ts", d_ts, ts2);
      check("lat2_pass", d_pass, {31'd0, exp_pass});
      check("lat2_fails", fail_count2, fc2);
    end

    // reset during LAT_TS
    id2 = 32'h1234_5678; ts2 = EXP_TS;
    start2 = 1;
    tick();
    start2 = 0;
    repeat (4) tick();
    check("prerst_state", {m_read2, busy2, m_address2}, 3'b011);
    check("prerst_id", id_value2, 32'h1234_5678);
    rst_n2 = 0;
    tick();
    rst_n2 = 1;
    check("midrst_flags", {m_read2, m_address2, busy2, done2, id_match2, ts_match2, pass2, timeout_err2}, 0);
    check("midrst_vals", id_value2 | ts_value2 | {24'd0, fail_count2}, 0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done2 === 1'b1 || busy2 === 1'b1 || m_read2 === 1'b1) ndone++;
    end
    check("midrst_quiet", ndone, 0);

    // periodic recheck with forced failures
    rst_nr = 1;
    since = 0;
    while (m_readr !== 1'b1 && since < 1000) begin
      tick();
      since++;
    end
    check("rc_first_read", since, 100);
    while (doner !== 1'b1 && since < 1000) begin
      tick();
      since++;
    end
    check("rc_first_done", since, 102);
    fcr = 1;
    check("rc_first_id", id_valuer, 32'hDEAD_BEEF);
    check("rc_first_fails", fail_countr, fcr);
    for (int k = 2; k <= 300; k++) begin
      since = 0;
      got = 0;
      while (!got && since < 1000) begin
        startr = (k == 2 && since == 100);
        tick();
        since++;
        got = (doner === 1'b1);
      end
      startr = 0;
      if (fcr < 255) fcr++;
      check("rc_period", since, 103);
      check("rc_fails", fail_countr, fcr);
      check("rc_pass", passr, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
